// File: rtl/apb_intc_pkg.sv
// Shared constants and types for the APB interrupt controller.
// Register offsets, ID width and the decoded-access record.
package apb_intc_pkg;

   localparam int ID_W = 5;
   localparam logic [ID_W-1:0] NONE_ID = '0;

   localparam logic [4:0] OFF_PENDING = 5'h00;
   localparam logic [4:0] OFF_MASK    = 5'h04;
   localparam logic [4:0] OFF_MODE    = 5'h08;
   localparam logic [4:0] OFF_CLAIM   = 5'h0C;
   localparam logic [4:0] OFF_NMI     = 5'h10;
   localparam int         OFF_LAST    = 'h10;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_PENDING,
      SEL_MASK,
      SEL_MODE,
      SEL_CLAIM,
      SEL_NMI
   } reg_sel_e;

   typedef struct packed {
      logic     acc;
      logic     wr;
      logic     err;
      reg_sel_e sel;
   } apb_dec_t;

   // Unaligned offsets inside the window select nothing and read 0.
   function automatic reg_sel_e decode_sel(input logic [4:0] off);
      case (off)
         OFF_PENDING: decode_sel = SEL_PENDING;
         OFF_MASK:    decode_sel = SEL_MASK;
         OFF_MODE:    decode_sel = SEL_MODE;
         OFF_CLAIM:   decode_sel = SEL_CLAIM;
         OFF_NMI:     decode_sel = SEL_NMI;
         default:     decode_sel = SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/apb_intc_prio.sv
// Fixed-priority encoder: lowest set bit wins, reported as index+1 (0 = none).
module apb_intc_prio
   import apb_intc_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0] vec,
   output logic [ID_W-1:0]    id
);

   always_comb begin
      id = NONE_ID;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (vec[i]) id = ID_W'(i + 1);
      end
   end

endmodule

// File: rtl/apb_intc.sv
// APB interrupt controller: edge/level sources, mask, claim, NMI status.
// Define APB_INTC_SYNC_EN to insert a 2-flop synchronizer on irq_src.
module apb_intc
   import apb_intc_pkg::*;
#(
   parameter int                    NUM_SRC    = 8,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h20000000
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pdata,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [3:0]            pstb,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  perr,
   input  logic [NUM_SRC-1:0]    irq_src,
   input  logic                  nmi,
   output logic                  cpu_interrupt,
   output logic [ID_W-1:0]       irq_id
);

   logic [ADDR_WIDTH-1:0] off;
   logic                  out_rng;
   apb_dec_t              dec;
   logic [DATA_WIDTH-1:0] be, wbits;
   logic                  wr_ok, rd_claim;
   logic                  we_pend, we_mask, we_mode, we_nmi;

   logic [NUM_SRC-1:0] pending, mask, mode, smp, hist;
   logic [NUM_SRC-1:0] pend_nxt, mask_nxt, mode_nxt, mode_chg;
   logic [NUM_SRC-1:0] rise, clr_w1c, claim_clr, active;
   logic [ID_W-1:0]    id_nxt;
   logic               nmi_stat;
   logic               unused_bits;

   // Address decode relative to the window base; below-base wraps large.
   assign off     = paddr - BASE_ADDR;
   assign out_rng = off > ADDR_WIDTH'(OFF_LAST);

   always_comb begin
      dec     = '0;
      dec.acc = psel & penable & ~pready;
      dec.wr  = pwrite;
      dec.sel = out_rng ? SEL_NONE : decode_sel(off[4:0]);
      dec.err = out_rng | (pwrite & (dec.sel == SEL_CLAIM));
   end

   for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_be
      if (b / 8 < 4) begin : g_on
         assign be[b] = pstb[b/8];
      end else begin : g_off
         assign be[b] = 1'b0;
      end
   end

   assign wbits    = pdata & be;
   assign wr_ok    = dec.acc & dec.wr & ~dec.err;
   assign rd_claim = dec.acc & ~dec.wr & ~dec.err & (dec.sel == SEL_CLAIM);
   assign we_pend  = wr_ok & (dec.sel == SEL_PENDING);
   assign we_mask  = wr_ok & (dec.sel == SEL_MASK);
   assign we_mode  = wr_ok & (dec.sel == SEL_MODE);
   assign we_nmi   = wr_ok & (dec.sel == SEL_NMI);
   assign unused_bits = &{1'b0, wbits[DATA_WIDTH-1:NUM_SRC]};

   assign clr_w1c  = we_pend ? wbits[NUM_SRC-1:0] : '0;
   assign mask_nxt = we_mask ? ((mask & ~be[NUM_SRC-1:0]) | wbits[NUM_SRC-1:0]) : mask;
   assign mode_nxt = we_mode ? ((mode & ~be[NUM_SRC-1:0]) | wbits[NUM_SRC-1:0]) : mode;
   assign mode_chg = mode ^ mode_nxt;

`ifdef APB_INTC_SYNC_EN
   logic [NUM_SRC-1:0] sync1, sync2;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync1 <= '0;
         sync2 <= '0;
         smp   <= '0;
      end else begin
         sync1 <= irq_src;
         sync2 <= sync1;
         smp   <= sync2;
      end
   end
`else
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) smp <= '0;
      else          smp <= irq_src;
   end
`endif

   assign rise   = smp & ~hist;
   assign active = pending & mask;

   // Edge sources: set beats any same-cycle clear. Level sources track input.
   always_comb begin
      pend_nxt  = '0;
      claim_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         claim_clr[i] = rd_claim & (irq_id == ID_W'(i + 1));
         if (mode_chg[i])  pend_nxt[i] = 1'b0;
         else if (mode[i]) pend_nxt[i] = rise[i] | (pending[i] & ~clr_w1c[i] & ~claim_clr[i]);
         else              pend_nxt[i] = smp[i];
      end
   end

   apb_intc_prio #(.NUM_SRC(NUM_SRC)) u_prio (
      .vec (active),
      .id  (id_nxt)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pending       <= '0;
         mask          <= '0;
         mode          <= '0;
         hist          <= '0;
         nmi_stat      <= 1'b0;
         irq_id        <= NONE_ID;
         cpu_interrupt <= 1'b0;
         pready        <= 1'b0;
         perr          <= 1'b0;
      end else begin
         pending       <= pend_nxt;
         mask          <= mask_nxt;
         mode          <= mode_nxt;
         hist          <= smp;
         nmi_stat      <= nmi | (nmi_stat & ~(we_nmi & wbits[0]));
         irq_id        <= id_nxt;
         cpu_interrupt <= (|active) | nmi_stat;
         pready        <= dec.acc;
         perr          <= dec.acc & dec.err;
      end
   end

   always_comb begin
      prdata = '0;
      case (dec.sel)
         SEL_PENDING: prdata = DATA_WIDTH'(pending);
         SEL_MASK:    prdata = DATA_WIDTH'(mask);
         SEL_MODE:    prdata = DATA_WIDTH'(mode);
         SEL_CLAIM:   prdata = DATA_WIDTH'(irq_id);
         SEL_NMI:     prdata[0] = nmi_stat;
         default:     prdata = '0;
      endcase
   end

endmodule

// File: tb/tb_apb_intc.sv
// Directed self-checking bench for apb_intc (default build, NUM_SRC=8).
module tb_apb_intc;
   import apb_intc_pkg::*;

   localparam int          NS   = 8;
   localparam logic [31:0] BASE = 32'h2000_0000;

   logic          pclk = 1'b0;
   logic          presetn = 1'b0;
   logic [31:0]   paddr = '0;
   logic [31:0]   pdata = '0;
   logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [3:0]    pstb = '0;
   logic [31:0]   prdata;
   logic          pready, perr;
   logic [NS-1:0] irq_src = '0;
   logic          nmi = 1'b0;
   logic          cpu_interrupt;
   logic [4:0]    irq_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 pclk = ~pclk;

   apb_intc #(.NUM_SRC(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
      .pclk(pclk), .presetn(presetn), .paddr(paddr), .pdata(pdata), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pstb(pstb), .prdata(prdata),
      .pready(pready), .perr(perr), .irq_src(irq_src), .nmi(nmi),
      .cpu_interrupt(cpu_interrupt), .irq_id(irq_id)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic xfer(input logic wr, input logic [31:0] off, input logic [31:0] wd,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err);
      paddr = BASE + off; pdata = wd; pwrite = wr; pstb = strb;
      psel = 1'b1; penable = 1'b0;
      tick(1);
      penable = 1'b1;
      rd = '0; err = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (pready) break;
      end
      if (!pready) begin
         n_vec++; n_err++;
         $display("FAIL apb_timeout: pready=%b required 1", pready);
      end else begin
         rd = prdata; err = perr;
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] strb,
                     output logic err);
      logic [31:0] dummy;
      xfer(1'b1, off, wd, strb, dummy, err);
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] d, output logic err);
      xfer(1'b0, off, '0, 4'h0, d, err);
   endtask

   task automatic test_reset;
      logic [31:0] d; logic e;
      tick(3);
      n_vec++; if (pready !== 1'b0) begin n_err++; $display("FAIL rst_pready: got %b want 0", pready); end
      n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", perr); end
      presetn = 1'b1;
      tick(1);
      n_vec++; if (cpu_interrupt !== 1'b0) begin n_err++; $display("FAIL rst_cpu_int: got %b want 0", cpu_interrupt); end
      n_vec++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL rst_irq_id: got %0d want 0", irq_id); end
      for (int r = 0; r <= 'h10; r += 4) begin
         rd(r, d, e);
         n_vec++;
         if (d !== 32'h0 || e !== 1'b0) begin
            n_err++; $display("FAIL rst_reg_%0h: got %h/err %b want 0/err 0", r, d, e);
         end
      end
   endtask

   task automatic test_claim;
      logic [31:0] d; logic e;
      wr(OFF_MODE, 32'h01, 4'hF, e);
      wr(OFF_MASK, 32'h01, 4'hF, e);
      irq_src = 8'h01; tick(1); irq_src = 8'h00; tick(3);
      n_vec++; if (cpu_interrupt !== 1'b1) begin n_err++; $display("FAIL claim_cpu_int_set: got %b want 1", cpu_interrupt); end
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL claim_pending_set: got %h want 1", d); end
      rd(OFF_CLAIM, d, e);
      n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL claim_value: got %h want 1", d); end
      tick(2);
      n_vec++; if (cpu_interrupt !== 1'b0) begin n_err++; $display("FAIL claim_cpu_int_clr: got %b want 0", cpu_interrupt); end
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL claim_pending_clr: got %h want 0", d); end
   endtask

   task automatic test_level;
      logic [31:0] d; logic e;
      wr(OFF_MODE, 32'h00, 4'hF, e);
      wr(OFF_MASK, 32'hFF, 4'hF, e);
      irq_src = 8'h0C; tick(4);
      n_vec++; if (irq_id !== 5'd3) begin n_err++; $display("FAIL level_irq_id: got %0d want 3", irq_id); end
      wr(OFF_PENDING, 32'h0C, 4'hF, e);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h0C) begin n_err++; $display("FAIL level_w1c_ignored: got %h want 0c", d); end
      rd(OFF_CLAIM, d, e);
      tick(2);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h0C) begin n_err++; $display("FAIL level_claim_ignored: got %h want 0c", d); end
      irq_src = 8'h00; tick(3);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL level_drop: got %h want 0", d); end
      tick(1);
      n_vec++; if (irq_id !== 5'd0) begin n_err++; $display("FAIL level_irq_id_none: got %0d want 0", irq_id); end
   endtask

   task automatic test_w1c_race;
      logic [31:0] d; logic e;
      wr(OFF_MODE, 32'h04, 4'hF, e);
      irq_src = 8'h04; tick(3); irq_src = 8'h00; tick(3);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h04) begin n_err++; $display("FAIL race_edge_set: got %h want 04", d); end
      // new rising edge lands on the same clock as the W1C commit
      irq_src = 8'h04;
      wr(OFF_PENDING, 32'h04, 4'hF, e);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h04) begin n_err++; $display("FAIL race_set_wins: got %h want 04", d); end
      wr(OFF_PENDING, 32'h04, 4'hF, e);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h00) begin n_err++; $display("FAIL race_plain_w1c: got %h want 00", d); end
      irq_src = 8'h00; tick(2);
   endtask

   task automatic test_priority;
      logic e;
      wr(OFF_MODE, 32'h00, 4'hF, e);
      wr(OFF_MASK, 32'hF0, 4'hF, e);
      irq_src = 8'h3C; tick(4);
      n_vec++; if (irq_id !== 5'd5) begin n_err++; $display("FAIL prio_masked: got %0d want 5", irq_id); end
      n_vec++; if (cpu_interrupt !== 1'b1) begin n_err++; $display("FAIL prio_cpu_int: got %b want 1", cpu_interrupt); end
      wr(OFF_MASK, 32'hFF, 4'hF, e); tick(3);
      n_vec++; if (irq_id !== 5'd3) begin n_err++; $display("FAIL prio_unmasked: got %0d want 3", irq_id); end
      irq_src = 8'h80; tick(4);
      n_vec++; if (irq_id !== 5'd8) begin n_err++; $display("FAIL prio_top_src: got %0d want 8", irq_id); end
      irq_src = 8'h00; tick(4);
      n_vec++; if (cpu_interrupt !== 1'b0) begin n_err++; $display("FAIL prio_idle_cpu_int: got %b want 0", cpu_interrupt); end
   endtask

   task automatic test_mode_change;
      logic [31:0] d; logic e;
      irq_src = 8'h02; tick(3);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h02) begin n_err++; $display("FAIL modechg_level_set: got %h want 02", d); end
      wr(OFF_MODE, 32'h02, 4'hF, e);
      rd(OFF_PENDING, d, e);
      n_vec++; if (d !== 32'h00) begin n_err++; $display("FAIL modechg_clear: got %h want 00", d); end
      irq_src = 8'h00;
      wr(OFF_MODE, 32'h00, 4'hF, e);
      tick(2);
   endtask

   task automatic test_errors;
      logic [31:0] d; logic e;
      wr(OFF_MASK, 32'h00, 4'hF, e);
      wr(32'h20, 32'hFF, 4'hF, e);
      n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_oob_write: perr %b want 1", e); end
      rd(OFF_MASK, d, e);
      n_vec++; if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL err_no_effect: got %h/err %b want 0/err 0", d, e); end
      wr(OFF_CLAIM, 32'h1, 4'hF, e);
      n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL err_claim_write: perr %b want 1", e); end
      rd(32'h20, d, e);
      n_vec++; if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL err_oob_read: got %h/err %b want 0/err 1", d, e); end
      wr(OFF_MASK, 32'hFFFF, 4'h1, e);
      rd(OFF_MASK, d, e);
      n_vec++; if (d !== 32'h00FF) begin n_err++; $display("FAIL strb_byte0: got %h want 00ff", d); end
      wr(OFF_MASK, 32'h0000, 4'h2, e);
      rd(OFF_MASK, d, e);
      n_vec++; if (d !== 32'h00FF) begin n_err++; $display("FAIL strb_byte1_only: got %h want 00ff", d); end
   endtask

   task automatic test_nmi;
      logic [31:0] d; logic e;
      wr(OFF_MASK, 32'h00, 4'hF, e);
      nmi = 1'b1; tick(1); nmi = 1'b0; tick(3);
      n_vec++; if (cpu_interrupt !== 1'b1) begin n_err++; $display("FAIL nmi_cpu_int_set: got %b want 1", cpu_interrupt); end
      rd(OFF_NMI, d, e);
      n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL nmi_stat_set: got %h want 1", d); end
      wr(OFF_NMI, 32'h1, 4'hF, e);
      tick(2);
      n_vec++; if (cpu_interrupt !== 1'b0) begin n_err++; $display("FAIL nmi_cpu_int_clr: got %b want 0", cpu_interrupt); end
      rd(OFF_NMI, d, e);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL nmi_stat_clr: got %h want 0", d); end
   endtask

   task automatic test_reset_abort;
      logic [31:0] d; logic e;
      wr(OFF_MASK, 32'h0F, 4'hF, e);
      paddr = BASE + OFF_MASK; pdata = 32'h55; pwrite = 1'b1; pstb = 4'hF;
      psel = 1'b1; penable = 1'b0;
      tick(1);
      penable = 1'b1;
      #2 presetn = 1'b0;
      tick(1);
      n_vec++; if (pready !== 1'b0) begin n_err++; $display("FAIL abort_pready: got %b want 0", pready); end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      tick(1);
      presetn = 1'b1;
      tick(2);
      n_vec++; if (pready !== 1'b0) begin n_err++; $display("FAIL abort_pready_after: got %b want 0", pready); end
      rd(OFF_MASK, d, e);
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL abort_no_commit: got %h want 0", d); end
   endtask

   initial begin
      test_reset;
      test_claim;
      test_level;
      test_w1c_race;
      test_priority;
      test_mode_change;
      test_errors;
      test_nmi;
      test_reset_abort;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
